// File: rtl/mpu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mpu_pkg
// Brief    : Shared constants, types and helpers for the MPU6050 frame path.
// Revision : 1.0 - initial release
// ============================================================================
package mpu_pkg;

  // Burst layout starting at register 0x3B, high byte first
  localparam int         FRAME_BYTES = 14;
  localparam logic [3:0] AXH = 4'd0;
  localparam logic [3:0] AXL = 4'd1;
  localparam logic [3:0] AYH = 4'd2;
  localparam logic [3:0] AYL = 4'd3;
  localparam logic [3:0] AZH = 4'd4;
  localparam logic [3:0] AZL = 4'd5;
  localparam logic [3:0] TH  = 4'd6;
  localparam logic [3:0] TL  = 4'd7;
  localparam logic [3:0] GXH = 4'd8;
  localparam logic [3:0] GXL = 4'd9;
  localparam logic [3:0] GYH = 4'd10;
  localparam logic [3:0] GYL = 4'd11;
  localparam logic [3:0] GZH = 4'd12;
  localparam logic [3:0] GZL = 4'd13;
  // Counter value once a frame has completed; held until the next start
  localparam logic [3:0] IDX_PARKED = 4'd14;

  // Accel Z reading for 1 g at the +/-2 g range
  localparam int ACC_1G = 16384;

  // Calibration FSM, one-hot
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_CALIB = 4'b0010;
  localparam logic [3:0] ST_DIV   = 4'b0100;
  localparam logic [3:0] ST_DONE  = 4'b1000;

  // Seven raw words of one burst, in register order
  typedef struct packed {
    logic signed [15:0] ax;
    logic signed [15:0] ay;
    logic signed [15:0] az;
    logic signed [15:0] temp;
    logic signed [15:0] gx;
    logic signed [15:0] gy;
    logic signed [15:0] gz;
  } raw_frame_t;

  // Clamp a 17-bit two's-complement value into the 16-bit signed range
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) begin
      return v[16] ? 16'sh8000 : 16'sh7FFF;
    end
    return v[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpu_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : mpu_frame_assembler
// Brief    : Collects the 14-byte burst into seven raw words, flags short and
//            overrun frames, and pulses frame_done one cycle after the last
//            byte.
// Revision : 1.0 - initial release
// ============================================================================
module mpu_frame_assembler
  import mpu_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       frame_start_in,
  input  logic       byte_valid_in,
  input  logic [7:0] byte_in,
  output logic       frame_done,
  output raw_frame_t frame_words,
  output logic       frame_err
);

  logic [3:0] r_idx;
  // Bytes 0..12 of the frame in flight; byte 13 goes straight to the shadow
  logic [7:0] r_buf [0:FRAME_BYTES-2];

  // Byte capture, frame completion and malformed-frame detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_words <= '0;
      for (int i = 0; i < FRAME_BYTES - 1; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (frame_start_in) begin
        // A start mid-frame abandons the partial data
        if (r_idx != 4'd0 && r_idx != IDX_PARKED) begin
          frame_err <= 1'b1;
        end
        if (byte_valid_in) begin
          r_buf[AXH] <= byte_in;
          r_idx      <= 4'd1;
        end else begin
          r_idx <= 4'd0;
        end
      end else if (byte_valid_in) begin
        if (r_idx == IDX_PARKED) begin
          frame_err <= 1'b1;
        end else if (r_idx == GZL) begin
          frame_words <= '{ax:   {r_buf[AXH], r_buf[AXL]},
                           ay:   {r_buf[AYH], r_buf[AYL]},
                           az:   {r_buf[AZH], r_buf[AZL]},
                           temp: {r_buf[TH],  r_buf[TL]},
                           gx:   {r_buf[GXH], r_buf[GXL]},
                           gy:   {r_buf[GYH], r_buf[GYL]},
                           gz:   {r_buf[GZH], byte_in}};
          frame_done  <= 1'b1;
          r_idx       <= IDX_PARKED;
        end else begin
          r_buf[r_idx] <= byte_in;
          r_idx        <= r_idx + 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mpu_frame_calib.sv
`default_nettype none
// ============================================================================
// Module   : mpu_frame_calib
// Brief    : MPU6050 burst consumer: averages frames into per-axis offsets in
//            calibrate mode and emits saturated, offset-corrected samples in
//            run mode.
// Revision : 1.0 - initial release
// ============================================================================
module mpu_frame_calib #(
  parameter int CALIB_SAMPLES = 1024,
  parameter int CALIB_LOG2    = 10,
  parameter int ACC_1G        = mpu_pkg::ACC_1G
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               mode_calib_in,
  input  logic               mode_run_in,
  input  logic               frame_start_in,
  input  logic               byte_valid_in,
  input  logic [7:0]         byte_in,
  output logic               calib_done,
  output logic               sample_valid_out,
  output logic signed [15:0] accel_x,
  output logic signed [15:0] accel_y,
  output logic signed [15:0] accel_z,
  output logic signed [15:0] temp_out,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               frame_err
);
  import mpu_pkg::*;

  localparam int AW     = 16 + CALIB_LOG2;
  localparam int CW     = CALIB_LOG2 + 1;
  localparam int NAX    = 6;   // ax, ay, az, gx, gy, gz
  localparam int AZ_IDX = 2;

  logic               w_frame_done;
  raw_frame_t         w_words;
  logic [3:0]         r_state;
  logic               r_calib_prev;
  logic [CW-1:0]      r_count;
  logic signed [AW-1:0] r_acc  [NAX];
  logic signed [15:0]   r_off  [NAX];
  logic signed [15:0]   w_raw  [NAX];
  logic signed [AW-1:0] w_term [NAX];
  logic signed [15:0]   w_corr [NAX];
  logic                 w_calib_rise;

  mpu_frame_assembler u_assembler (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .frame_start_in (frame_start_in),
    .byte_valid_in  (byte_valid_in),
    .byte_in        (byte_in),
    .frame_done     (w_frame_done),
    .frame_words    (w_words),
    .frame_err      (frame_err)
  );

  assign w_calib_rise = mode_calib_in & ~r_calib_prev;

  // Per-axis accumulator terms (accel Z has gravity removed) and corrected values
  always_comb begin
    w_raw[0] = w_words.ax;
    w_raw[1] = w_words.ay;
    w_raw[2] = w_words.az;
    w_raw[3] = w_words.gx;
    w_raw[4] = w_words.gy;
    w_raw[5] = w_words.gz;
    for (int i = 0; i < NAX; i++) begin
      w_term[i] = AW'(w_raw[i]);
      w_corr[i] = sat16({w_raw[i][15], w_raw[i]} - {r_off[i][15], r_off[i]});
    end
    w_term[AZ_IDX] = AW'(w_raw[AZ_IDX]) - AW'(ACC_1G);
  end

  // Calibration FSM: accumulate CALIB_SAMPLES frames, then divide into offsets
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_calib_prev <= 1'b0;
      r_count      <= '0;
      calib_done   <= 1'b0;
      for (int i = 0; i < NAX; i++) begin
        r_acc[i] <= '0;
        r_off[i] <= '0;
      end
    end else begin
      r_calib_prev <= mode_calib_in;
      if (w_calib_rise) begin
        // Restart from any state; old offsets stay until the next DIV
        for (int i = 0; i < NAX; i++) begin
          r_acc[i] <= '0;
        end
        r_count    <= '0;
        calib_done <= 1'b0;
        r_state    <= ST_CALIB;
      end else begin
        case (r_state)
          ST_CALIB: begin
            if (!mode_calib_in) begin
              r_state <= ST_IDLE;
            end else if (w_frame_done) begin
              for (int i = 0; i < NAX; i++) begin
                r_acc[i] <= r_acc[i] + w_term[i];
              end
              r_count <= r_count + CW'(1);
              if (r_count == CW'(CALIB_SAMPLES - 1)) begin
                r_state <= ST_DIV;
              end
            end
          end
          ST_DIV: begin
            if (!mode_calib_in) begin
              r_state <= ST_IDLE;
            end else begin
              for (int i = 0; i < NAX; i++) begin
                r_off[i] <= 16'(r_acc[i] >>> CALIB_LOG2);
              end
              calib_done <= 1'b1;
              r_state    <= ST_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Corrected sample output; calibrate mode overrides run mode
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid_out <= 1'b0;
      accel_x          <= '0;
      accel_y          <= '0;
      accel_z          <= '0;
      temp_out         <= '0;
      gyro_x           <= '0;
      gyro_y           <= '0;
      gyro_z           <= '0;
    end else begin
      sample_valid_out <= 1'b0;
      if (w_frame_done && mode_run_in && !mode_calib_in && calib_done) begin
        accel_x          <= w_corr[0];
        accel_y          <= w_corr[1];
        accel_z          <= w_corr[2];
        temp_out         <= w_words.temp;
        gyro_x           <= w_corr[3];
        gyro_y           <= w_corr[4];
        gyro_z           <= w_corr[5];
        sample_valid_out <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
